// File: rtl/seg7_scan_driver_if.sv
// Bus between the display driver and its client logic.
//   load       : one-cycle capture request for data_in/dp_in/en_in
//   data_in    : NUM_DIGITS hex nibbles, digit i at [4i+3:4i]
//   dp_in      : per-digit decimal point
//   en_in      : per-digit enable
//   seg        : segment bus {a..g, dp} at pin polarity
//   dig        : digit select lines at pin polarity
//   frame_tick : one-cycle pulse when the scan index returns to digit 0
//   pending    : captured data waits for the next frame boundary
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   dig;
    logic                    frame_tick;
    logic                    pending;

    modport master (
        output load, data_in, dp_in, en_in,
        input  seg, dig, frame_tick, pending
    );

    modport slave (
        input  load, data_in, dp_in, en_in,
        output seg, dig, frame_tick, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with double-buffered data.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : seg7_scan_driver_if slave (load/data/dp/en in; seg/dig/frame_tick/pending out)
// Each digit owns CLK_DIV cycles; new data is committed only at the frame wrap.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned CLK_DIV        = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ       = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
    // Pin-level "nothing lit / no digit selected" patterns.
    localparam logic [7:0]            SegOff = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DigOff = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [DivW-1:0]                 div_q, div_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]      act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]           act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]           act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0][3:0]      sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]           sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]           sh_en_q, sh_en_d;
    logic                            pending_q, pending_d;
    logic                            tick_q, tick_d;
    logic [7:0]                      seg_q, seg_d;
    logic [NUM_DIGITS-1:0]           dig_q, dig_d;

    logic                            slot_end;
    logic                            wrap;
    logic [NUM_DIGITS-1:0]           blank;
    logic                            upper_zero;
    logic [7:0]                      seg_l;
    logic [NUM_DIGITS-1:0]           dig_l;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Slot divider, scan index and double-buffer commit.
    always_comb begin
        slot_end   = (div_q == DivLast);
        wrap       = slot_end && (idx_q == IdxLast);
        div_d      = slot_end ? '0 : div_q + DivW'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IdxW'(1);
        end
        tick_d     = wrap;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        pending_d  = pending_q;
        if (wrap) begin
            // A load on the wrap cycle bypasses the shadow and supersedes it.
            if (bus.load) begin
                act_data_d = bus.data_in;
                act_dp_d   = bus.dp_in;
                act_en_d   = bus.en_in;
            end else if (pending_q) begin
                act_data_d = sh_data_q;
                act_dp_d   = sh_dp_q;
                act_en_d   = sh_en_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            sh_data_d = bus.data_in;
            sh_dp_d   = bus.dp_in;
            sh_en_d   = bus.en_in;
            pending_d = 1'b1;
        end
    end

    // Digit i>0 blanks when it and every higher digit are zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (act_data_q[i] == 4'h0);
            blank[i]   = BLANK_LZ && upper_zero;
        end
    end

    // Registered pin drive for the digit selected by the current index.
    always_comb begin
        seg_l = {decode(act_data_q[idx_q]), act_dp_q[idx_q]};
        if (blank[idx_q]) begin
            seg_l[7:1] = '0;
        end
        dig_l = '0;
        if (act_en_q[idx_q]) begin
            dig_l[idx_q] = 1'b1;
        end else begin
            seg_l = '0;
        end
        seg_d = seg_l ^ SegOff;
        dig_d = dig_l ^ DigOff;
    end

    // Enables come out of reset set so the all-zero display is visible at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            idx_q      <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '1;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '1;
            pending_q  <= 1'b0;
            tick_q     <= 1'b0;
            seg_q      <= SegOff;
            dig_q      <= DigOff;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig        = dig_q;
    assign bus.frame_tick = tick_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (active-high pins and
// active-low pins) driven identically; expectations are in logical polarity.
module tb_seg7_scan_driver;
    localparam int unsigned ND = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0),
        .BLANK_LZ(1'b1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1),
        .BLANK_LZ(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic        load;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        int          adv;
        logic [7:0]  seg;
        logic [3:0]  dig;
        logic        tick;
        logic        pend;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t v(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] en, input int adv, input logic [7:0] s,
                               input logic [3:0] dg, input logic tk, input logic pd);
        vec_t r;
        r.load = ld; r.data = d; r.dp = dp; r.en = en; r.adv = adv;
        r.seg = s; r.dig = dg; r.tick = tk; r.pend = pd;
        return r;
    endfunction

    task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] en);
        bus0.load = ld; bus0.data_in = d; bus0.dp_in = dp; bus0.en_in = en;
        bus1.load = ld; bus1.data_in = d; bus1.dp_in = dp; bus1.en_in = en;
    endtask

    // Advance n edges, sampling 1 time unit after each; load lasts one edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                bus0.load = 1'b0;
                bus1.load = 1'b0;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input string name, input logic [7:0] s, input logic [3:0] dg,
                         input logic tk, input logic pd);
        cmp({name, ".seg0"}, bus0.seg, s);
        cmp({name, ".dig0"}, {4'b0, bus0.dig}, {4'b0, dg});
        cmp({name, ".seg1"}, bus1.seg, ~s);
        cmp({name, ".dig1"}, {4'b0, bus1.dig}, {4'b0, ~dg});
        cmp({name, ".tick"}, {6'b0, bus0.frame_tick, bus1.frame_tick}, {6'b0, tk, tk});
        cmp({name, ".pend"}, {6'b0, bus0.pending, bus1.pending}, {6'b0, pd, pd});
    endtask

    initial begin
        // Logical segment codes {a..g,dp}: 0=FC 2=DA 3=F2 7=E0 8=FE A=EE F=8E
        vecs[0]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  1, 8'hFC, 4'b0001, 1'b0, 1'b0);
        vecs[1]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  3, 8'hFC, 4'b0001, 1'b0, 1'b0);
        vecs[2]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  1, 8'h00, 4'b0010, 1'b0, 1'b0);
        vecs[3]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  4, 8'h00, 4'b0100, 1'b0, 1'b0);
        vecs[4]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  4, 8'h00, 4'b1000, 1'b0, 1'b0);
        vecs[5]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  3, 8'h00, 4'b1000, 1'b1, 1'b0);
        vecs[6]  = v(1'b0, 16'h0000, 4'h0, 4'hF,  1, 8'hFC, 4'b0001, 1'b0, 1'b0);
        // Mid-frame load: old data stays up until the wrap.
        vecs[7]  = v(1'b1, 16'h0A37, 4'h2, 4'hF,  1, 8'hFC, 4'b0001, 1'b0, 1'b1);
        vecs[8]  = v(1'b0, 16'h0A37, 4'h2, 4'hF,  3, 8'h00, 4'b0010, 1'b0, 1'b1);
        vecs[9]  = v(1'b0, 16'h0A37, 4'h2, 4'hF, 11, 8'h00, 4'b1000, 1'b1, 1'b0);
        vecs[10] = v(1'b0, 16'h0A37, 4'h2, 4'hF,  1, 8'hE0, 4'b0001, 1'b0, 1'b0);
        vecs[11] = v(1'b0, 16'h0A37, 4'h2, 4'hF,  4, 8'hF3, 4'b0010, 1'b0, 1'b0);
        vecs[12] = v(1'b0, 16'h0A37, 4'h2, 4'hF,  4, 8'hEE, 4'b0100, 1'b0, 1'b0);
        vecs[13] = v(1'b0, 16'h0A37, 4'h2, 4'hF,  4, 8'h00, 4'b1000, 1'b0, 1'b0);
        vecs[14] = v(1'b0, 16'h0A37, 4'h2, 4'hF,  3, 8'h00, 4'b1000, 1'b1, 1'b0);
        // Two loads in one frame: the last wins.
        vecs[15] = v(1'b1, 16'h1111, 4'h0, 4'hF,  1, 8'hE0, 4'b0001, 1'b0, 1'b1);
        vecs[16] = v(1'b1, 16'h2222, 4'h0, 4'hF,  1, 8'hE0, 4'b0001, 1'b0, 1'b1);
        vecs[17] = v(1'b0, 16'h2222, 4'h0, 4'hF, 14, 8'h00, 4'b1000, 1'b1, 1'b0);
        vecs[18] = v(1'b0, 16'h2222, 4'h0, 4'hF,  1, 8'hDA, 4'b0001, 1'b0, 1'b0);
        vecs[19] = v(1'b0, 16'h2222, 4'h0, 4'hF,  4, 8'hDA, 4'b0010, 1'b0, 1'b0);
        vecs[20] = v(1'b0, 16'h2222, 4'h0, 4'hF, 10, 8'hDA, 4'b1000, 1'b0, 1'b0);
        // Load on the wrap edge goes straight to the active set.
        vecs[21] = v(1'b1, 16'hFFFF, 4'h0, 4'hF,  1, 8'hDA, 4'b1000, 1'b1, 1'b0);
        vecs[22] = v(1'b0, 16'hFFFF, 4'h0, 4'hF,  1, 8'h8E, 4'b0001, 1'b0, 1'b0);
        vecs[23] = v(1'b0, 16'hFFFF, 4'h0, 4'hF,  4, 8'h8E, 4'b0010, 1'b0, 1'b0);
        vecs[24] = v(1'b0, 16'hFFFF, 4'h0, 4'hF,  8, 8'h8E, 4'b1000, 1'b0, 1'b0);
        // Disabled digits 1 and 3 keep their slot time but light nothing.
        vecs[25] = v(1'b1, 16'h8888, 4'h0, 4'h5,  1, 8'h8E, 4'b1000, 1'b0, 1'b1);
        vecs[26] = v(1'b0, 16'h8888, 4'h0, 4'h5,  2, 8'h8E, 4'b1000, 1'b1, 1'b0);
        vecs[27] = v(1'b0, 16'h8888, 4'h0, 4'h5,  1, 8'hFE, 4'b0001, 1'b0, 1'b0);
        vecs[28] = v(1'b0, 16'h8888, 4'h0, 4'h5,  4, 8'h00, 4'b0000, 1'b0, 1'b0);
        vecs[29] = v(1'b0, 16'h8888, 4'h0, 4'h5,  3, 8'h00, 4'b0000, 1'b0, 1'b0);
        vecs[30] = v(1'b0, 16'h8888, 4'h0, 4'h5,  1, 8'hFE, 4'b0100, 1'b0, 1'b0);
        vecs[31] = v(1'b0, 16'h8888, 4'h0, 4'h5,  4, 8'h00, 4'b0000, 1'b0, 1'b0);
        vecs[32] = v(1'b0, 16'h8888, 4'h0, 4'h5,  3, 8'h00, 4'b0000, 1'b1, 1'b0);
        vecs[33] = v(1'b0, 16'h8888, 4'h0, 4'h5,  1, 8'hFE, 4'b0001, 1'b0, 1'b0);

        rst = 1'b1;
        drive(1'b0, 16'h0000, 4'h0, 4'hF);
        step(3);
        check("reset", 8'h00, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            if (vecs[i].load) begin
                drive(1'b1, vecs[i].data, vecs[i].dp, vecs[i].en);
            end
            step(vecs[i].adv);
            check($sformatf("row%0d", i), vecs[i].seg, vecs[i].dig, vecs[i].tick,
                  vecs[i].pend);
        end

        // Mid-slot reset with data pending: everything returns to reset values.
        drive(1'b1, 16'h1234, 4'hF, 4'hF);
        step(1);
        check("pre_rst", 8'hFE, 4'b0001, 1'b0, 1'b1);
        rst = 1'b1;
        step(1);
        check("mid_rst", 8'h00, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        check("post_rst_d0a", 8'hFC, 4'b0001, 1'b0, 1'b0);
        step(3);
        check("post_rst_d0b", 8'hFC, 4'b0001, 1'b0, 1'b0);
        step(1);
        check("post_rst_d1", 8'h00, 4'b0010, 1'b0, 1'b0);
        step(11);
        check("post_rst_tick", 8'h00, 4'b1000, 1'b1, 1'b0);
        step(1);
        check("post_rst_f1", 8'hFC, 4'b0001, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
